// File: rtl/dst_accumulator.sv
// Four-lane scatter-add accumulator: per-lane partial-sum banks updated by a
// read-modify-write pipeline, drained as 4-way sums over a ready/valid stream.
module dst_accumulator #(
  parameter int ADDRW  = 16,
  parameter int WL     = 32,
  parameter int DEPTHW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [ADDRW-1:0]  dst0,
  input  logic [ADDRW-1:0]  dst1,
  input  logic [ADDRW-1:0]  dst2,
  input  logic [ADDRW-1:0]  dst3,
  input  logic              valid0,
  input  logic              valid1,
  input  logic              valid2,
  input  logic              valid3,
  input  logic [WL-1:0]     value0,
  input  logic [WL-1:0]     value1,
  input  logic [WL-1:0]     value2,
  input  logic [WL-1:0]     value3,
  input  logic              start_drain,
  output logic [DEPTHW-1:0] out_addr,
  output logic [WL-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              range_err,
  output logic              overrun
);

  localparam int DEPTH = 1 << DEPTHW;
  localparam logic [DEPTHW-1:0] LAST = '1;

  localparam logic [2:0] INIT  = 3'd0;
  localparam logic [2:0] ACCUM = 3'd1;
  localparam logic [2:0] FLUSH = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  logic [2:0]        state;
  logic [DEPTHW-1:0] init_cnt;
  logic              flush_cnt;
  logic [DEPTHW:0]   rd_cnt;
  logic              rd_pending;
  logic [DEPTHW-1:0] pend_addr;

  logic [3:0][ADDRW-1:0] dst;
  logic [3:0]            valid;
  logic [3:0][WL-1:0]    value;

  assign dst   = {dst3, dst2, dst1, dst0};
  assign valid = {valid3, valid2, valid1, valid0};
  assign value = {value3, value2, value1, value0};

  logic [3:0]             in_range;
  logic [3:0]             accept;
  logic [3:0]             s1_valid;
  logic [3:0][DEPTHW-1:0] s1_addr;
  logic [3:0][WL-1:0]     s1_value;
  logic [3:0]             s2_valid;
  logic [3:0][DEPTHW-1:0] s2_addr;
  logic [3:0][WL-1:0]     s2_sum;
  logic [3:0][WL-1:0]     rdata;
  logic [3:0][WL-1:0]     sum;

  logic [3:0]             mem_we;
  logic [3:0]             mem_re;
  logic [3:0][DEPTHW-1:0] mem_wa;
  logic [3:0][DEPTHW-1:0] mem_ra;
  logic [3:0][WL-1:0]     mem_wd;

  logic          drain_issue;
  logic          load_out;
  logic          last_accept;
  logic [WL-1:0] sum4;

  assign busy = (state != ACCUM);
  assign done = (state == FIN);

  // Read for the next address only when the output register will be free at
  // the same edge; the held read register acts as the skid while stalled.
  assign drain_issue = (state == DRAIN) && !rd_cnt[DEPTHW] && (!out_valid || out_ready);
  assign load_out    = rd_pending && (!out_valid || out_ready);
  assign last_accept = (state == DRAIN) && out_valid && out_ready && (out_addr == LAST);
  assign sum4        = rdata[0] + rdata[1] + rdata[2] + rdata[3];

  always_comb begin
    in_range = '0;
    accept   = '0;
    sum      = '0;
    mem_we   = '0;
    mem_re   = '0;
    mem_wa   = '0;
    mem_ra   = '0;
    mem_wd   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      in_range[k] = ((dst[k] >> DEPTHW) == '0);
      accept[k]   = valid[k] && in_range[k] && (state == ACCUM);
      // Previous cycle's write to the same address is not yet visible in rdata.
      sum[k] = ((s2_valid[k] && (s2_addr[k] == s1_addr[k])) ? s2_sum[k] : rdata[k])
               + s1_value[k];
      mem_we[k] = ena && ((state == INIT) || drain_issue || s1_valid[k]);
      mem_wa[k] = (state == INIT) ? init_cnt :
                  (drain_issue ? rd_cnt[DEPTHW-1:0] : s1_addr[k]);
      mem_wd[k] = ((state == INIT) || drain_issue) ? '0 : sum[k];
      mem_re[k] = ena && (accept[k] || drain_issue);
      mem_ra[k] = drain_issue ? rd_cnt[DEPTHW-1:0] : dst[k][DEPTHW-1:0];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_bank
    logic [WL-1:0] mem [DEPTH];
    logic [WL-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (mem_we[g]) mem[mem_wa[g]] <= mem_wd[g];
      if (mem_re[g]) rd_q <= mem[mem_ra[g]];
    end
    assign rdata[g] = rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      init_cnt  <= '0;
      flush_cnt <= 1'b0;
      rd_cnt    <= '0;
    end else if (ena) begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + DEPTHW'(1);
          if (init_cnt == LAST) state <= ACCUM;
        end
        ACCUM: begin
          if (start_drain) begin
            state     <= FLUSH;
            flush_cnt <= 1'b0;
          end
        end
        FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) begin
            state  <= DRAIN;
            rd_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_issue) rd_cnt <= rd_cnt + (DEPTHW+1)'(1);
          if (last_accept) state <= FIN;
        end
        FIN:     state <= ACCUM;
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= '0;
      s1_addr  <= '0;
      s1_value <= '0;
      s2_valid <= '0;
      s2_addr  <= '0;
      s2_sum   <= '0;
    end else if (ena) begin
      for (int unsigned k = 0; k < 4; k++) begin
        s1_valid[k] <= accept[k];
        if (accept[k]) begin
          s1_addr[k]  <= dst[k][DEPTHW-1:0];
          s1_value[k] <= value[k];
        end
        s2_valid[k] <= s1_valid[k];
        s2_addr[k]  <= s1_addr[k];
        s2_sum[k]   <= sum[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
      pend_addr  <= '0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
    end else if (ena) begin
      if (drain_issue) begin
        rd_pending <= 1'b1;
        pend_addr  <= rd_cnt[DEPTHW-1:0];
      end else if (load_out) begin
        rd_pending <= 1'b0;
      end
      if (load_out) begin
        out_valid <= 1'b1;
        out_addr  <= pend_addr;
        out_data  <= sum4;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (ena) begin
      if (|(valid & ~in_range)) range_err <= 1'b1;
      if (busy && |valid)       overrun   <= 1'b1;
    end
  end

endmodule
